instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 24 ++
 rtl/instruction_fetch_unit_fetch_pc_reg.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage, instruction memory and decode.
// Holds the fetch FSM state encoding, bus-width defaults, the halt encoding
// and a saturating counter helper.
package instruction_fetch_unit_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_INST_WIDTH = 32;
  localparam int unsigned DEF_MEM_DEPTH  = 256;
  localparam int unsigned COUNT_WIDTH    = 16;

  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   advance         - step the PC by one word (wraps at ADDR_WIDTH)
//   redirect_valid  - load redirect_pc; wins over advance
//   redirect_pc     - redirect target
//   pc              - current PC
module fetch_pc_reg #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(0)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Reset > redirect > advance > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the PC into a zero-latency instruction memory, captures
// the returned word into an instruction register and hands it to decode with
// a valid/ready handshake. Supports redirect, halt on HALT_WORD and
// backpressure.
// Optional: define FETCH_BOUNDS_CHECK_EN to suppress loads from pc >= MEM_DEPTH,
// raising a sticky fetch_fault and halting instead.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   inst_address / read_data     - memory read port (combinational)
//   instr, instr_pc, instr_valid - held instruction to decode
//   instr_ready                  - decode accepts the held instruction
//   redirect_valid, redirect_pc  - load new PC and flush held instruction
//   halted                       - fetch stopped
//   fetch_count                  - saturating count of loaded instructions
//   fetch_fault                  - sticky out-of-range fault
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           INST_WIDTH = DEF_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(0),
  parameter int unsigned           MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter logic [INST_WIDTH-1:0] HALT_WORD  = INST_WIDTH'(DEF_HALT_WORD)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  inst_address,
  input  logic [INST_WIDTH-1:0]  read_data,
  output logic [INST_WIDTH-1:0]  instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count,
  output logic                   fetch_fault
);

  // Elaboration-time sanity check on the implemented memory size.
  if (MEM_DEPTH == 0) begin : g_bad_mem_depth
    $error("instruction_fetch_unit: MEM_DEPTH must be nonzero");
  end

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  want_load;
  logic                  load;
  logic                  halt_hit;
  logic                  fault_hit;

  // PC register; it holds on a halt word so halted fetch parks on it.
  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .reset          (reset),
    .advance        (load && !halt_hit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  assign inst_address = pc;
  assign halted       = (state == ST_HALTED);

`ifdef FETCH_BOUNDS_CHECK_EN
  logic out_of_range;
  assign out_of_range = (32'(pc) >= 32'(MEM_DEPTH));
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; a redirect always resumes fetching.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = ST_FETCH;
    end else begin
      case (state)
        ST_BOOT:   state_next = ST_FETCH;
        ST_FETCH:  if (halt_hit || fault_hit) state_next = ST_HALTED;
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_BOOT;
      endcase
    end
  end

  // FSM outputs: load only when the instruction slot is free or being drained.
  always_comb begin
    want_load = 1'b0;
    load      = 1'b0;
    halt_hit  = 1'b0;
    fault_hit = 1'b0;
    want_load = (state == ST_FETCH) && !redirect_valid && (!instr_valid || instr_ready);
`ifdef FETCH_BOUNDS_CHECK_EN
    load      = want_load && !out_of_range;
    fault_hit = want_load && out_of_range;
`else
    load      = want_load;
`endif
    halt_hit  = load && (read_data == HALT_WORD);
  end

  // Instruction register, valid flag and load counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= read_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      fetch_count <= sat_inc(fetch_count);
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  // Sticky until reset; redirects do not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else if (fault_hit) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed vector table, hand-written
// halt / wrap / bounds / saturation / reset sequences and a randomized phase
// compared against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inst_address;
  logic [31:0] read_data;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic        fetch_fault;

  logic [31:0] mem [0:65535];
  assign read_data = mem[inst_address];

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_WIDTH (16),
    .INST_WIDTH (32),
    .RESET_PC   (16'h0000),
    .MEM_DEPTH  (256),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_address   (inst_address),
    .read_data      (read_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .fetch_fault    (fetch_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 = boot, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc, m_ipc, m_count;
  logic [31:0] m_instr;
  logic        m_valid, m_fault;

  task automatic model_edge(input logic rst, input logic rdy, input logic rv,
                            input logic [15:0] rpc);
    bit want;
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 16'h0000; m_ipc = 16'h0000; m_instr = 32'h0;
      m_valid = 1'b0; m_count = 16'h0000; m_fault = 1'b0;
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_mode = 1;
    end else begin
      want = (m_mode == 1) && (!m_valid || rdy);
      if (want && BOUNDS && (int'(m_pc) >= 256)) begin
        m_fault = 1'b1; m_mode = 2;
      end else if (want) begin
        w = mem[m_pc];
        m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (w == HALT) m_mode = 2;
        else m_pc = m_pc + 16'd1;
      end else begin
        if (m_valid && rdy) m_valid = 1'b0;
        if (m_mode == 0) m_mode = 1;
      end
    end
  endtask

  // Drive inputs at negedge, clock, update the model, sample 1 time unit later.
  task automatic step(input logic rst, input logic rdy, input logic rv,
                      input logic [15:0] rpc);
    @(negedge clk);
    reset = rst; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_edge(rst, rdy, rv, rpc);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                           input logic [15:0] ipc, input logic [15:0] addr,
                           input logic hlt, input logic [15:0] cnt, input logic flt);
    chk({tag, ".valid"},   32'(instr_valid),  32'(v));
    chk({tag, ".instr"},   instr,             ins);
    chk({tag, ".instr_pc"},32'(instr_pc),     32'(ipc));
    chk({tag, ".address"}, 32'(inst_address), 32'(addr));
    chk({tag, ".halted"},  32'(halted),       32'(hlt));
    chk({tag, ".count"},   32'(fetch_count),  32'(cnt));
    chk({tag, ".fault"},   32'(fetch_fault),  32'(flt));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_valid, m_instr, m_ipc, m_pc, (m_mode == 2), m_count, m_fault);
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [15:0] e_ipc;
    logic [15:0] e_addr;
    logic [15:0] e_count;
  } vec_t;

  vec_t tbl [10];

  task automatic fill_pattern(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) mem[i] = {16'hA5A5, 16'(i)};
  endtask

  initial begin
    bit done;
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    fill_pattern(0, 65535);
    mem[0] = 32'h2000_0004; mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222; mem[3] = 32'h3333_3333;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    check_all("reset", 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);

    // Directed stream: boot cycle, loads, backpressure, release, redirect.
    tbl[0] = '{1'b1, 1'b0, 16'h0,    1'b0, 32'h0000_0000, 16'h0,  16'h0,  16'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0,    1'b1, 32'h2000_0004, 16'h0,  16'h1,  16'd1};
    tbl[2] = '{1'b0, 1'b0, 16'h0,    1'b1, 32'h2000_0004, 16'h0,  16'h1,  16'd1};
    tbl[3] = '{1'b0, 1'b0, 16'h0,    1'b1, 32'h2000_0004, 16'h0,  16'h1,  16'd1};
    tbl[4] = '{1'b0, 1'b0, 16'h0,    1'b1, 32'h2000_0004, 16'h0,  16'h1,  16'd1};
    tbl[5] = '{1'b1, 1'b0, 16'h0,    1'b1, 32'h1111_1111, 16'h1,  16'h2,  16'd2};
    tbl[6] = '{1'b1, 1'b0, 16'h0,    1'b1, 32'h2222_2222, 16'h2,  16'h3,  16'd3};
    tbl[7] = '{1'b1, 1'b0, 16'h0,    1'b1, 32'h3333_3333, 16'h3,  16'h4,  16'd4};
    tbl[8] = '{1'b1, 1'b1, 16'h0040, 1'b0, 32'h3333_3333, 16'h3,  16'h40, 16'd4};
    tbl[9] = '{1'b1, 1'b0, 16'h0,    1'b1, 32'hA5A5_0040, 16'h40, 16'h41, 16'd5};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      check_all($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_ipc,
                tbl[i].e_addr, 1'b0, tbl[i].e_count, 1'b0);
    end

    // Halt word at address 2: delivered, then fetch parks until a redirect.
    mem[2] = HALT;
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    check_all("halt.redir", 1'b0, 32'hA5A5_0040, 16'h40, 16'h0, 1'b0, 16'd5, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("halt.ld0", 1'b1, 32'h2000_0004, 16'h0, 16'h1, 1'b0, 16'd6, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("halt.ld1", 1'b1, 32'h1111_1111, 16'h1, 16'h2, 1'b0, 16'd7, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("halt.word", 1'b1, HALT, 16'h2, 16'h2, 1'b1, 16'd8, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check_all("halt.stall", 1'b1, HALT, 16'h2, 16'h2, 1'b1, 16'd8, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("halt.drain", 1'b0, HALT, 16'h2, 16'h2, 1'b1, 16'd8, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("halt.park", 1'b0, HALT, 16'h2, 16'h2, 1'b1, 16'd8, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    check_all("halt.exit", 1'b0, HALT, 16'h2, 16'h0, 1'b0, 16'd8, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("halt.resume", 1'b1, 32'h2000_0004, 16'h0, 16'h1, 1'b0, 16'd9, 1'b0);
    mem[2] = 32'h2222_2222;

`ifdef FETCH_BOUNDS_CHECK_EN
    // Out-of-range fetch faults and halts; fault survives a redirect.
    step(1'b0, 1'b1, 1'b1, 16'h0100);
    check_all("bnd.redir", 1'b0, 32'h2000_0004, 16'h0, 16'h100, 1'b0, 16'd9, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("bnd.fault", 1'b0, 32'h2000_0004, 16'h0, 16'h100, 1'b1, 16'd9, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("bnd.park", 1'b0, 32'h2000_0004, 16'h0, 16'h100, 1'b1, 16'd9, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    check_all("bnd.exit", 1'b0, 32'h2000_0004, 16'h0, 16'h0, 1'b0, 16'd9, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("bnd.resume", 1'b1, 32'h2000_0004, 16'h0, 16'h1, 1'b0, 16'd10, 1'b1);
`else
    // PC wraps from FFFF to 0000.
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    check_all("wrap.redir", 1'b0, 32'h2000_0004, 16'h0, 16'hFFFF, 1'b0, 16'd9, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("wrap.top", 1'b1, 32'hA5A5_FFFF, 16'hFFFF, 16'h0, 1'b0, 16'd10, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_all("wrap.zero", 1'b1, 32'h2000_0004, 16'h0, 16'h1, 1'b0, 16'd11, 1'b0);
`endif

    // Randomized traffic against the model, with halt words sprinkled in.
    for (int i = 0; i < 512; i++)
      mem[i] = ($urandom_range(0, 19) == 0) ? HALT : $urandom();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0),
           16'($urandom_range(0, 300)));
      check_model($sformatf("rnd%0d", i));
    end

    // Saturation: stream loads inside the implemented range until FFFF.
    fill_pattern(0, 511);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    check_model("sat.start");
    done = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      if (m_pc == 16'h00FF) step(1'b0, 1'b1, 1'b1, 16'h0000);
      else                  step(1'b0, 1'b1, 1'b0, 16'h0);
      if (m_count == 16'hFFFF) done = 1'b1;
      if ((i % 256) == 0) check_model($sformatf("sat%0d", i));
    end
    chk("sat.reached", 32'(done), 32'd1);
    check_model("sat.full");
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("sat.hold.valid", 32'(instr_valid), 32'd1);
    chk("sat.hold.count", 32'(fetch_count), 32'h0000_FFFF);
    check_model("sat.hold");

    // Mid-stream reset discards the held instruction.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    check_all("rst.mid", 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
